// File: rtl/fp_pkg.sv
// fp_pkg
// Shared definitions for the pipelined floating-point multiplier:
//   - rounding-mode encodings (RND_*)
//   - bit positions inside the 4-bit exception flag vector (FLAG_*)
//   - operand class enum (zero / normal / inf / NaN)
//   - width-parametrised helpers for the exponent bias, the canonical
//     NaN pattern, the largest finite magnitude and operand classification
// No ports; imported by fp_mult_pipe and fp_round_pack.
package fp_pkg;

  localparam logic [1:0] RND_RNE = 2'd0;
  localparam logic [1:0] RND_RTZ = 2'd1;
  localparam logic [1:0] RND_RUP = 2'd2;
  localparam logic [1:0] RND_RDN = 2'd3;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  function automatic int fp_bias(input int expWidth);
    return (1 << (expWidth - 1)) - 1;
  endfunction

  // Sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] fp_canon_nan(input int expWidth, input int manWidth);
    logic [63:0] pat;
    pat = ((64'd1 << expWidth) - 64'd1) << manWidth;
    pat = pat | (64'd1 << (manWidth - 1));
    return pat;
  endfunction

  // Magnitude only (no sign bit): exponent all ones minus one, mantissa all ones.
  function automatic logic [63:0] fp_max_finite(input int expWidth, input int manWidth);
    logic [63:0] pat;
    pat = ((64'd1 << expWidth) - 64'd2) << manWidth;
    pat = pat | ((64'd1 << manWidth) - 64'd1);
    return pat;
  endfunction

  // Subnormals (exponent field zero) are treated as zero regardless of mantissa.
  function automatic fp_class_e fp_classify(input logic expZero, input logic expOnes,
                                            input logic manZero);
    if (expZero) return FP_ZERO;
    if (expOnes) return manZero ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack
// Final (third) stage of the multiplier, purely combinational: applies the
// selected rounding mode to a normalised significand, detects overflow and
// underflow, resolves special operand combinations and packs the result.
// Ports:
//   sign_i         sign of the product
//   clsA_i/clsB_i  class of each original operand
//   exp_i          normalised biased exponent, signed, EXP_WIDTH+2 bits
//   man_i          kept mantissa bits (hidden bit excluded)
//   guard_i        first bit below the kept mantissa
//   sticky_i       OR of every bit below the guard bit
//   rnd_i          rounding mode (RND_*)
//   result_o       packed product
//   flags_o        {invalid, overflow, underflow, inexact}
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                       sign_i,
  input  fp_class_e                  clsA_i,
  input  fp_class_e                  clsB_i,
  input  logic [EXP_WIDTH+1:0]       exp_i,
  input  logic [MAN_WIDTH-1:0]       man_i,
  input  logic                       guard_i,
  input  logic                       sticky_i,
  input  logic [1:0]                 rnd_i,
  output logic [EXP_WIDTH+MAN_WIDTH:0] result_o,
  output logic [3:0]                 flags_o
);

  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int WM = W - 1;
  localparam logic [W-1:0]  NAN_PAT = W'(fp_canon_nan(EXP_WIDTH, MAN_WIDTH));
  localparam logic [WM-1:0] MAX_MAG = WM'(fp_max_finite(EXP_WIDTH, MAN_WIDTH));
  localparam logic [WM-1:0] INF_MAG = {{EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
  localparam logic [EXP_WIDTH+1:0] EXP_OVF = {2'b00, {EXP_WIDTH{1'b1}}};

  logic                 inexact;
  logic                 roundUp;
  logic [MAN_WIDTH:0]   manSum;
  logic [EXP_WIDTH+1:0] expRnd;
  logic                 tooSmall;
  logic                 tooBig;
  logic                 toInf;
  logic                 anyNan;
  logic                 anyInf;
  logic                 anyZero;
  logic                 zeroTimesInf;

  // Rounding increment decision for each mode.
  always_comb begin
    inexact = guard_i | sticky_i;
    case (rnd_i)
      RND_RNE: roundUp = guard_i & (sticky_i | man_i[0]);
      RND_RTZ: roundUp = 1'b0;
      RND_RUP: roundUp = inexact & ~sign_i;
      default: roundUp = inexact & sign_i;
    endcase
  end

  // A carry out of the mantissa leaves the mantissa at zero and bumps the exponent.
  assign manSum = {1'b0, man_i} + {{MAN_WIDTH{1'b0}}, roundUp};
  assign expRnd = exp_i + {{(EXP_WIDTH+1){1'b0}}, manSum[MAN_WIDTH]};

  // Underflow looks at the unrounded exponent; a negative exponent has its MSB set.
  assign tooSmall = exp_i[EXP_WIDTH+1] | (exp_i == '0);
  assign tooBig   = (expRnd >= EXP_OVF);

  // On overflow, infinity is returned only when rounding moves away from zero.
  assign toInf = (rnd_i == RND_RNE) |
                 ((rnd_i == RND_RUP) & ~sign_i) |
                 ((rnd_i == RND_RDN) & sign_i);

  assign anyNan  = (clsA_i == FP_NAN) | (clsB_i == FP_NAN);
  assign anyInf  = (clsA_i == FP_INF) | (clsB_i == FP_INF);
  assign anyZero = (clsA_i == FP_ZERO) | (clsB_i == FP_ZERO);
  assign zeroTimesInf = anyInf & anyZero;

  // Special cases are resolved first, in priority order, and raise no
  // overflow/underflow/inexact; only 0 x inf is invalid.
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    if (anyNan) begin
      result_o = NAN_PAT;
    end else if (zeroTimesInf) begin
      result_o = NAN_PAT;
      flags_o[FLAG_NV] = 1'b1;
    end else if (anyInf) begin
      result_o = {sign_i, INF_MAG};
    end else if (anyZero) begin
      result_o = {sign_i, {WM{1'b0}}};
    end else if (tooSmall) begin
      result_o = {sign_i, {WM{1'b0}}};
      flags_o[FLAG_UF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else if (tooBig) begin
      result_o = toInf ? {sign_i, INF_MAG} : {sign_i, MAX_MAG};
      flags_o[FLAG_OF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else begin
      result_o = {sign_i, expRnd[EXP_WIDTH-1:0], manSum[MAN_WIDTH-1:0]};
      flags_o[FLAG_NX] = inexact;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control on both sides, per-operation rounding mode and a pass-through tag.
// Subnormal operands and results are flushed to zero.
//   Stage 1: unpack, classify, exponent sum, exact significand product
//   Stage 2: normalise and form kept mantissa, guard and sticky bits
//   Stage 3: round, handle specials and pack (fp_round_pack), registered out
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   in_valid/ready   operand handshake; a, b, rnd_mode, in_tag captured on transfer
//   out_valid/ready  result handshake; result, out_tag, flags held while stalled
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int TAG_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] b,
  input  logic [1:0]                   rnd_mode,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0] result,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic [3:0]                   flags
);

  localparam int W   = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int PW  = 2 * MAN_WIDTH + 2;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH+1:0] BIAS_X = EW2'(fp_bias(EXP_WIDTH));

  logic adv;

  logic [EXP_WIDTH-1:0] expA, expB;
  logic [MAN_WIDTH-1:0] manA, manB;

  fp_class_e            s1ClsA_d, s1ClsB_d;
  logic                 s1Sign_d;
  logic [EXP_WIDTH+1:0] s1Exp_d;
  logic [PW-1:0]        s1Prod_d;

  logic                 s1Valid_q, s1Sign_q;
  fp_class_e            s1ClsA_q, s1ClsB_q;
  logic [EXP_WIDTH+1:0] s1Exp_q;
  logic [PW-1:0]        s1Prod_q;
  logic [1:0]           s1Rnd_q;
  logic [TAG_WIDTH-1:0] s1Tag_q;

  logic [EXP_WIDTH+1:0] s2Exp_d;
  logic [MAN_WIDTH-1:0] s2Man_d;
  logic                 s2Guard_d, s2Sticky_d;

  logic                 s2Valid_q, s2Sign_q;
  fp_class_e            s2ClsA_q, s2ClsB_q;
  logic [EXP_WIDTH+1:0] s2Exp_q;
  logic [MAN_WIDTH-1:0] s2Man_q;
  logic                 s2Guard_q, s2Sticky_q;
  logic [1:0]           s2Rnd_q;
  logic [TAG_WIDTH-1:0] s2Tag_q;

  logic [W-1:0]         s3Result_d;
  logic [3:0]           s3Flags_d;

  logic                 s3Valid_q;
  logic [W-1:0]         s3Result_q;
  logic [3:0]           s3Flags_q;
  logic [TAG_WIDTH-1:0] s3Tag_q;

  // The whole pipe moves together; it only freezes when the output register
  // holds a result the consumer is not taking.
  assign adv       = !s3Valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3Valid_q;
  assign result    = s3Result_q;
  assign out_tag   = s3Tag_q;
  assign flags     = s3Flags_q;

  assign expA = a[W-2:MAN_WIDTH];
  assign expB = b[W-2:MAN_WIDTH];
  assign manA = a[MAN_WIDTH-1:0];
  assign manB = b[MAN_WIDTH-1:0];

  assign s1ClsA_d = fp_classify(expA == '0, expA == '1, manA == '0);
  assign s1ClsB_d = fp_classify(expB == '0, expB == '1, manB == '0);
  assign s1Sign_d = a[W-1] ^ b[W-1];
  assign s1Exp_d  = {2'b00, expA} + {2'b00, expB} - BIAS_X;
  // Operands are widened to the product width so the multiply is exact.
  assign s1Prod_d = {{(MAN_WIDTH+1){1'b0}}, 1'b1, manA} *
                    {{(MAN_WIDTH+1){1'b0}}, 1'b1, manB};

  // The product of two [1,2) significands lies in [1,4); when it reaches 2
  // the hidden bit sits one place higher and everything shifts down by one.
  always_comb begin
    if (s1Prod_q[PW-1]) begin
      s2Exp_d    = s1Exp_q + {{(EXP_WIDTH+1){1'b0}}, 1'b1};
      s2Man_d    = s1Prod_q[PW-2:MAN_WIDTH+1];
      s2Guard_d  = s1Prod_q[MAN_WIDTH];
      s2Sticky_d = |s1Prod_q[MAN_WIDTH-1:0];
    end else begin
      s2Exp_d    = s1Exp_q;
      s2Man_d    = s1Prod_q[PW-3:MAN_WIDTH];
      s2Guard_d  = s1Prod_q[MAN_WIDTH-1];
      s2Sticky_d = |s1Prod_q[MAN_WIDTH-2:0];
    end
  end

  fp_round_pack #(
    .EXP_WIDTH(EXP_WIDTH),
    .MAN_WIDTH(MAN_WIDTH)
  ) u_round_pack (
    .sign_i  (s2Sign_q),
    .clsA_i  (s2ClsA_q),
    .clsB_i  (s2ClsB_q),
    .exp_i   (s2Exp_q),
    .man_i   (s2Man_q),
    .guard_i (s2Guard_q),
    .sticky_i(s2Sticky_q),
    .rnd_i   (s2Rnd_q),
    .result_o(s3Result_d),
    .flags_o (s3Flags_d)
  );

  // Reset clears every stage, dropping anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1Valid_q  <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1ClsA_q   <= FP_ZERO;
      s1ClsB_q   <= FP_ZERO;
      s1Exp_q    <= '0;
      s1Prod_q   <= '0;
      s1Rnd_q    <= '0;
      s1Tag_q    <= '0;
      s2Valid_q  <= 1'b0;
      s2Sign_q   <= 1'b0;
      s2ClsA_q   <= FP_ZERO;
      s2ClsB_q   <= FP_ZERO;
      s2Exp_q    <= '0;
      s2Man_q    <= '0;
      s2Guard_q  <= 1'b0;
      s2Sticky_q <= 1'b0;
      s2Rnd_q    <= '0;
      s2Tag_q    <= '0;
      s3Valid_q  <= 1'b0;
      s3Result_q <= '0;
      s3Flags_q  <= '0;
      s3Tag_q    <= '0;
    end else if (adv) begin
      s1Valid_q  <= in_valid;
      s1Sign_q   <= s1Sign_d;
      s1ClsA_q   <= s1ClsA_d;
      s1ClsB_q   <= s1ClsB_d;
      s1Exp_q    <= s1Exp_d;
      s1Prod_q   <= s1Prod_d;
      s1Rnd_q    <= rnd_mode;
      s1Tag_q    <= in_tag;
      s2Valid_q  <= s1Valid_q;
      s2Sign_q   <= s1Sign_q;
      s2ClsA_q   <= s1ClsA_q;
      s2ClsB_q   <= s1ClsB_q;
      s2Exp_q    <= s2Exp_d;
      s2Man_q    <= s2Man_d;
      s2Guard_q  <= s2Guard_d;
      s2Sticky_q <= s2Sticky_d;
      s2Rnd_q    <= s1Rnd_q;
      s2Tag_q    <= s1Tag_q;
      s3Valid_q  <= s2Valid_q;
      s3Result_q <= s3Result_d;
      s3Flags_q  <= s3Flags_d;
      s3Tag_q    <= s2Tag_q;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe
// Self-checking bench for fp_mult_pipe at its default single-precision
// parameters. Directed vectors carry literal expected values; random traffic
// is checked against an integer-arithmetic reference of the multiply.
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rnd_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  int checks = 0;
  int passes = 0;

  fp_mult_pipe #(
    .EXP_WIDTH(8),
    .MAN_WIDTH(23),
    .TAG_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .rnd_mode (rnd_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, then round by comparing the dropped
  // remainder with one half. Returns {flags, result}.
  function automatic logic [35:0] refMul(input logic [31:0] x, input logic [31:0] y,
                                         input logic [1:0] rm);
    int ex, ey, e, sh;
    longint p, qv, r, half;
    logic sgn, inexact, up, toInf;
    logic xNan, yNan, xInf, yInf, xZero, yZero;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xZero = (ex == 0);
    yZero = (ey == 0);
    xInf  = (ex == 255) && (x[22:0] == 0);
    yInf  = (ey == 255) && (y[22:0] == 0);
    xNan  = (ex == 255) && (x[22:0] != 0);
    yNan  = (ey == 255) && (y[22:0] != 0);
    sgn   = x[31] ^ y[31];
    if (xNan || yNan) return {4'b0000, 32'h7FC00000};
    if ((xZero && yInf) || (xInf && yZero)) return {4'b1000, 32'h7FC00000};
    if (xInf || yInf) return {4'b0000, sgn, 8'hFF, 23'h0};
    if (xZero || yZero) return {4'b0000, sgn, 31'h0};
    p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    sh = (p >= (longint'(1) << 47)) ? 24 : 23;
    qv = p >> sh;
    r  = p - (qv << sh);
    half = longint'(1) << (sh - 1);
    e  = ex + ey - 127 + (sh - 23);
    if (e < 1) return {4'b0011, sgn, 31'h0};
    inexact = (r != 0);
    case (rm)
      2'd0:    up = (r > half) || ((r == half) && qv[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = inexact && !sgn;
      default: up = inexact && sgn;
    endcase
    qv = qv + longint'(up);
    if (qv == (longint'(1) << 24)) begin
      qv = longint'(1) << 23;
      e  = e + 1;
    end
    if (e >= 255) begin
      toInf = (rm == 2'd0) || ((rm == 2'd2) && !sgn) || ((rm == 2'd3) && sgn);
      return {4'b0101, toInf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF}};
    end
    return {3'b000, inexact, sgn, e[7:0], qv[22:0]};
  endfunction

  // Operand mix weighted toward normals, with zeros, inf/NaN and exponent
  // extremes so overflow and underflow show up regularly.
  function automatic logic [31:0] randOperand();
    int unsigned sel;
    logic [7:0]  e;
    logic [22:0] m;
    sel = $urandom_range(0, 15);
    m   = 23'($urandom);
    case (sel)
      0:       e = 8'd0;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 0) m = '0;
      end
      2:       e = 8'($urandom_range(1, 8));
      3:       e = 8'($urandom_range(240, 254));
      4: begin
        e = 8'($urandom_range(100, 154));
        m = '1;
      end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Drive one operand pair onto the input port.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                               input logic [1:0] rm, input logic [3:0] tag);
    a        = opA;
    b        = opB;
    rnd_mode = rm;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Issue one operation into an idle pipe with the output always ready and
  // collect what comes out; lat counts edges from presentation to out_valid.
  task automatic issueAndWait(input logic [31:0] opA, input logic [31:0] opB,
                              input logic [1:0] rm, input logic [3:0] tag,
                              output logic [31:0] res, output logic [3:0] flg,
                              output logic [3:0] tg, output int lat);
    out_ready = 1'b1;
    applyStimulus(opA, opB, rm, tag);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    flg = flags;
    tg  = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    applyStimulus(32'h3F800000, 32'h3F800000, 2'd0, 4'h0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    else passes++;
    checks++;
    if (result !== 32'h0) $display("[TB] FAIL reset_result got=%h want=00000000", result);
    else passes++;
    checks++;
    if (out_tag !== 4'h0) $display("[TB] FAIL reset_out_tag got=%h want=0", out_tag);
    else passes++;
    checks++;
    if (flags !== 4'h0) $display("[TB] FAIL reset_flags got=%b want=0000", flags);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] res;
    logic [3:0]  flg, tg;
    int          lat;
    issueAndWait(32'h3FC00000, 32'h40000000, 2'd0, 4'hA, res, flg, tg, lat);
    checks++;
    if (res !== 32'h40400000) $display("[TB] FAIL basic_result got=%h want=40400000", res);
    else passes++;
    checks++;
    if (flg !== 4'b0000) $display("[TB] FAIL basic_flags got=%b want=0000", flg);
    else passes++;
    checks++;
    if (tg !== 4'hA) $display("[TB] FAIL basic_tag got=%h want=a", tg);
    else passes++;
    checks++;
    if (lat != 3) $display("[TB] FAIL basic_latency got=%0d want=3", lat);
    else passes++;
  endtask

  task automatic test_rounding();
    logic [31:0] expRes [4];
    logic [31:0] res;
    logic [3:0]  flg, tg;
    int          lat;
    expRes = '{32'h3F800002, 32'h3F800002, 32'h3F800003, 32'h3F800002};
    for (int rm = 0; rm < 4; rm++) begin
      issueAndWait(32'h3F800001, 32'h3F800001, 2'(rm), 4'(rm + 5), res, flg, tg, lat);
      checks++;
      if (res !== expRes[rm])
        $display("[TB] FAIL round_result mode=%0d got=%h want=%h", rm, res, expRes[rm]);
      else passes++;
      checks++;
      if (flg !== 4'b0001) $display("[TB] FAIL round_flags mode=%0d got=%b want=0001", rm, flg);
      else passes++;
      checks++;
      if (tg !== 4'(rm + 5)) $display("[TB] FAIL round_tag mode=%0d got=%h want=%h", rm, tg, 4'(rm + 5));
      else passes++;
      checks++;
      if (lat != 3) $display("[TB] FAIL round_latency mode=%0d got=%0d want=3", rm, lat);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] opA [4];
    logic [1:0]  rms [4];
    logic [31:0] expRes [4];
    logic [31:0] res;
    logic [3:0]  flg, tg;
    int          lat;
    opA    = '{32'h7F000000, 32'h7F000000, 32'hFF000000, 32'hFF000000};
    rms    = '{2'd0, 2'd1, 2'd2, 2'd3};
    expRes = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
    for (int i = 0; i < 4; i++) begin
      issueAndWait(opA[i], 32'h40000000, rms[i], 4'(i), res, flg, tg, lat);
      checks++;
      if (res !== expRes[i]) $display("[TB] FAIL ovf_result case=%0d got=%h want=%h", i, res, expRes[i]);
      else passes++;
      checks++;
      if (flg !== 4'b0101) $display("[TB] FAIL ovf_flags case=%0d got=%b want=0101", i, flg);
      else passes++;
      checks++;
      if (lat != 3) $display("[TB] FAIL ovf_latency case=%0d got=%0d want=3", i, lat);
      else passes++;
    end
  endtask

  task automatic test_specials();
    logic [31:0] opA [4];
    logic [31:0] opB [4];
    logic [31:0] expRes [4];
    logic [3:0]  expFlg [4];
    logic [31:0] res;
    logic [3:0]  flg, tg;
    int          lat;
    opA    = '{32'h00000000, 32'h7FC00001, 32'h00800000, 32'h80000000};
    opB    = '{32'h7F800000, 32'h3F800000, 32'h3F000000, 32'h40000000};
    expRes = '{32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h80000000};
    expFlg = '{4'b1000, 4'b0000, 4'b0011, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      issueAndWait(opA[i], opB[i], 2'd0, 4'(i + 8), res, flg, tg, lat);
      checks++;
      if (res !== expRes[i]) $display("[TB] FAIL special_result case=%0d got=%h want=%h", i, res, expRes[i]);
      else passes++;
      checks++;
      if (flg !== expFlg[i]) $display("[TB] FAIL special_flags case=%0d got=%b want=%b", i, flg, expFlg[i]);
      else passes++;
      checks++;
      if (lat != 3) $display("[TB] FAIL special_latency case=%0d got=%0d want=3", i, lat);
      else passes++;
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] opA [4];
    logic [31:0] opB [4];
    logic [39:0] sb[$];
    logic [39:0] exp40;
    logic [39:0] snap;
    int          sent, recv;
    logic        sawValid, started, gap;
    for (int i = 0; i < 4; i++) begin
      opA[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      opB[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    sent      = 0;
    sawValid  = 1'b0;
    snap      = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (sent < 4) applyStimulus(opA[sent], opB[sent], 2'd0, 4'(sent + 1));
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready cycle=%0d got=%b want=0", cyc, in_ready);
        else passes++;
        if (sawValid) begin
          checks++;
          if ({out_tag, flags, result} !== snap)
            $display("[TB] FAIL bp_hold cycle=%0d got=%h want=%h", cyc, {out_tag, flags, result}, snap);
          else passes++;
        end
        sawValid = 1'b1;
        snap     = {out_tag, flags, result};
      end
      if (in_valid && in_ready) begin
        sb.push_back({4'(sent + 1), refMul(opA[sent], opB[sent], 2'd0)});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (sawValid !== 1'b1) $display("[TB] FAIL bp_stalled_valid got=%b want=1", sawValid);
    else passes++;
    recv    = 0;
    started = 1'b0;
    gap     = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && recv < 4; cyc++) begin
      if (sent < 4) applyStimulus(opA[sent], opB[sent], 2'd0, 4'(sent + 1));
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        started = 1'b1;
        exp40 = (sb.size() > 0) ? sb.pop_front() : 40'h0;
        checks++;
        if ({out_tag, flags, result} !== exp40)
          $display("[TB] FAIL bp_drain idx=%0d got=%h want=%h", recv, {out_tag, flags, result}, exp40);
        else passes++;
        recv++;
      end else if (started) begin
        gap = 1'b1;
      end
      if (in_valid && in_ready) begin
        sb.push_back({4'(sent + 1), refMul(opA[sent], opB[sent], 2'd0)});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 4) $display("[TB] FAIL bp_count got=%0d want=4", recv);
    else passes++;
    checks++;
    if (gap !== 1'b0) $display("[TB] FAIL bp_consecutive got=%b want=0", gap);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_no_duplicate got=%b want=0", out_valid);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [3:0]  flg, tg;
    int          lat;
    out_ready = 1'b1;
    applyStimulus(32'h3FC00000, 32'h3FC00000, 2'd0, 4'h1);
    @(posedge clk);
    #1;
    applyStimulus(32'h40400000, 32'h40400000, 2'd0, 4'h2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid got=%b want=0", out_valid);
    else passes++;
    checks++;
    if ({out_tag, flags, result} !== 40'h0)
      $display("[TB] FAIL midrst_outputs got=%h want=0000000000", {out_tag, flags, result});
    else passes++;
    rst = 1'b1;
    issueAndWait(32'h40000000, 32'h40000000, 2'd0, 4'h7, res, flg, tg, lat);
    checks++;
    if (lat != 3) $display("[TB] FAIL midrst_latency got=%0d want=3", lat);
    else passes++;
    checks++;
    if ({tg, flg, res} !== {4'h7, 4'h0, 32'h40800000})
      $display("[TB] FAIL midrst_result got=%h want=%h", {tg, flg, res}, {4'h7, 4'h0, 32'h40800000});
    else passes++;
  endtask

  task automatic test_random();
    logic [39:0] sb[$];
    logic [39:0] exp40;
    logic [31:0] pa, pb;
    logic [1:0]  prm;
    logic [3:0]  ptag;
    logic        pending;
    int          sent, recv, cyc;
    localparam int NOPS = 300;
    sent    = 0;
    recv    = 0;
    cyc     = 0;
    pending = 1'b0;
    pa = '0; pb = '0; prm = '0; ptag = '0;
    while ((sent < NOPS || sb.size() > 0) && cyc < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && sent < NOPS && $urandom_range(0, 4) != 0) begin
        pa      = randOperand();
        pb      = randOperand();
        prm     = 2'($urandom_range(0, 3));
        ptag    = 4'($urandom);
        pending = 1'b1;
      end
      if (pending) applyStimulus(pa, pb, prm, ptag);
      else in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready))
        $display("[TB] FAIL rand_in_ready cycle=%0d got=%b want=%b", cyc, in_ready, !out_valid || out_ready);
      else passes++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("[TB] FAIL rand_unexpected got=%h want=none", {out_tag, flags, result});
        end else begin
          exp40 = sb.pop_front();
          if ({out_tag, flags, result} !== exp40)
            $display("[TB] FAIL rand_result idx=%0d got=%h want=%h", recv, {out_tag, flags, result}, exp40);
          else passes++;
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({ptag, refMul(pa, pb, prm)});
        sent++;
        pending = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != NOPS) $display("[TB] FAIL rand_drain got=%0d want=%0d", recv, NOPS);
    else passes++;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    rnd_mode  = '0;
    in_tag    = '0;
    #1;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_specials();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
